// File: rtl/in_reg_fifo_if.sv
// in_reg_fifo_if: sample-source/consumer handshake bundle for the input capture FIFO
interface in_reg_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      level;
  logic             overflow;
  logic             scan_enable;
  logic             test_mode;
  modport master (
    output in_data, in_valid, out_ready, scan_enable, test_mode,
    input  in_ready, out_data, out_valid, level, overflow
  );
  modport slave (
    input  in_data, in_valid, out_ready, scan_enable, test_mode,
    output in_ready, out_data, out_valid, level, overflow
  );
endinterface

// File: rtl/in_reg_fifo.sv
// in_reg_fifo: DEPTH-entry elastic input buffer with level and sticky overflow; IN_REG_FIFO_DROP_CNT_EN adds a saturating drop counter
module in_reg_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  in_reg_fifo_if.slave   bus
`ifdef IN_REG_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]     drop_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             overflow_q, overflow_d;
  logic             in_ready, out_valid, wr, rd, drop;
  logic             unused_dft;
  assign unused_dft    = bus.scan_enable ^ bus.test_mode;
  assign in_ready      = level_q != LW'(DEPTH);
  assign out_valid     = level_q != '0;
  assign wr            = bus.in_valid && in_ready;
  assign rd            = out_valid && bus.out_ready;
  assign drop          = bus.in_valid && !in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.level     = level_q;
  assign bus.overflow  = overflow_q;
  // next state: store on accepted write, advance pointers, track occupancy and overflow
  always_comb begin
    mem_d = mem_q;
    if (wr) mem_d[wr_ptr_q] = bus.in_data;
    wr_ptr_d   = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = (wr && !rd) ? level_q + LW'(1) : (rd && !wr) ? level_q - LW'(1) : level_q;
    overflow_d = overflow_q || drop;
  end
  // state register; reset discards all held samples and any same-cycle traffic
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end
`ifdef IN_REG_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  assign drop_cnt = drop_cnt_q;
  // count every rejected write attempt, saturating at all-ones
  always_comb begin
    drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end
  // drop counter register
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else drop_cnt_q <= drop_cnt_d;
  end
`endif
endmodule

// File: tb/tb_in_reg_fifo.sv
// tb_in_reg_fifo: random and directed checks of in_reg_fifo against a queue model
module tb_in_reg_fifo;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  bit en = 1'b0;
  logic [W-1:0] mq [$];
  bit m_ovf;
  int m_drop;
  logic [31:0] trace [2][16];
  in_reg_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
`ifdef IN_REG_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt;
  in_reg_fifo #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus), .drop_cnt(drop_cnt));
`else
  in_reg_fifo #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_drop = 0;
    end else begin
      automatic bit full = mq.size() == D;
      if (bus.in_valid && full) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      if (bus.out_ready && mq.size() != 0) void'(mq.pop_front());
      if (bus.in_valid && !full) mq.push_back(bus.in_data);
    end
  end
  always @(negedge clk) begin
    if (en) begin
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, mq.size() != D});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mq.size() != 0});
      chk("out_data", {24'd0, bus.out_data}, mq.size() != 0 ? {24'd0, mq[0]} : 32'd0);
      chk("level", {29'd0, bus.level}, mq.size());
      chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
`ifdef IN_REG_FIFO_DROP_CNT_EN
      chk("drop_cnt", {24'd0, drop_cnt}, m_drop);
`endif
    end
  end
  task automatic idle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask
  function automatic logic [31:0] sig();
    return {17'd0, bus.level, bus.out_data, bus.out_valid, bus.in_ready, bus.overflow};
  endfunction
  task automatic fill_ovf(input bit dft, input int run);
    int k;
    k = 0;
    bus.scan_enable = dft;
    bus.test_mode = dft;
    idle();
    do_reset();
    for (int v = 1; v <= 4; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(v);
      step();
      trace[run][k++] = sig();
    end
    chk("fill_level", {29'd0, bus.level}, 32'd4);
    chk("fill_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_data = 8'h05;
    for (int i = 0; i < 3; i++) begin
      step();
      trace[run][k++] = sig();
    end
    chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    chk("ovf_level", {29'd0, bus.level}, 32'd4);
`ifdef IN_REG_FIFO_DROP_CNT_EN
    chk("ovf_drop_cnt", {24'd0, drop_cnt}, 32'd3);
`endif
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", {24'd0, bus.out_data}, i);
      step();
      trace[run][k++] = sig();
    end
    bus.out_ready = 1'b0;
    chk("drain_empty", {31'd0, bus.out_valid}, 32'd0);
    chk("drain_ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.scan_enable = 1'b0;
    bus.test_mode = 1'b0;
  endtask
  initial begin
    bus.in_data = '0;
    bus.scan_enable = 1'b0;
    bus.test_mode = 1'b0;
    idle();
    step();
    reset = 1'b0;
    en = 1'b1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_level", {29'd0, bus.level}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data = 8'hA5;
    step();
    bus.in_valid = 1'b0;
    chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("single_data", {24'd0, bus.out_data}, 32'hA5);
    chk("single_level", {29'd0, bus.level}, 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("single_level0", {29'd0, bus.level}, 32'd0);
    chk("single_valid0", {31'd0, bus.out_valid}, 32'd0);
    chk("single_data0", {24'd0, bus.out_data}, 32'd0);
    fill_ovf(1'b0, 0);
    fill_ovf(1'b1, 1);
    for (int k = 0; k < 11; k++) chk("dft_trace", trace[1][k], trace[0][k]);
    do_reset();
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.in_data = W'(8'h10 + i);
      if (i > 0) begin
        chk("stream_data", {24'd0, bus.out_data}, 32'h10 + i - 1);
        chk("stream_level", {29'd0, bus.level}, 32'd1);
      end
      step();
    end
    bus.in_valid = 1'b0;
    chk("stream_last", {24'd0, bus.out_data}, 32'h1B);
    step();
    idle();
    chk("stream_empty", {31'd0, bus.out_valid}, 32'd0);
    do_reset();
    bus.in_valid = 1'b1;
    for (int v = 1; v <= 5; v++) begin
      bus.in_data = W'(v);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("mid_level3", {29'd0, bus.level}, 32'd3);
    chk("mid_ovf1", {31'd0, bus.overflow}, 32'd1);
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hEE;
    step();
    reset = 1'b0;
    idle();
    chk("mid_level0", {29'd0, bus.level}, 32'd0);
    chk("mid_valid0", {31'd0, bus.out_valid}, 32'd0);
    chk("mid_ovf0", {31'd0, bus.overflow}, 32'd0);
    chk("mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    chk("mid_not_stored", {29'd0, bus.level}, 32'd0);
    for (int c = 0; c < 3000; c++) begin
      automatic int bias = (c / 250) % 3;
      bus.in_valid = ($urandom_range(0, 9) < (bias == 0 ? 8 : bias == 1 ? 3 : 5));
      bus.out_ready = ($urandom_range(0, 9) < (bias == 0 ? 3 : bias == 1 ? 8 : 5));
      bus.in_data = W'($urandom);
      bus.scan_enable = $urandom_range(0, 1) == 1;
      bus.test_mode = $urandom_range(0, 1) == 1;
      reset = $urandom_range(0, 199) == 0;
      step();
    end
    reset = 1'b0;
    idle();
    step();
    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
